tx_frame_scheduler: RTL and testbench

Transmit-side controller for the serial link. It shares one serial output line between NUM_REQ byte requesters using round-robin arbitration. Each granted byte is framed as start(0), D0..D7 (LSB first), odd parity, stop(1), which is the frame format the receiver/decoder pair checks. It sits in front of the line driver, mirroring the receive path.

---
 rtl/tx_frame_scheduler_pkg.sv | 27 ++
 rtl/tx_frame_scheduler_rr_arbiter.sv | 33 +++
 rtl/tx_frame_scheduler.sv | 158 +++++++++++++++
 tb/tb_tx_frame_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_frame_scheduler_pkg.sv
// Shared definitions for the transmit frame scheduler: FSM state encoding,
// line levels and sizing helpers.
package tx_frame_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Line bits per frame: start + payload + parity + stop.
  function automatic int unsigned frame_bits(input int unsigned dw);
    return dw + 3;
  endfunction

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned gnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_frame_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping cyclically.
module tx_frame_scheduler_rr_arbiter
  import tx_frame_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned GNT_W   = gnt_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GNT_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [GNT_W-1:0]   o_gnt_idx,
  output logic               o_any
);

  // Rotated priority search starting at the pointer.
  always_comb begin
    int unsigned w_idx;
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_idx     = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      w_idx = (32'(i_ptr) + off) % NUM_REQ;
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = GNT_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Transmit frame scheduler: arbitrates NUM_REQ byte requesters onto one
// serial line, framing each byte as start, LSB-first data, odd parity, stop.
// Optional macro TX_SCHED_PRIO0_EN gives requester 0 strict priority.
module tx_frame_scheduler
  import tx_frame_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 1,
  localparam int unsigned GNT_W       = gnt_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [GNT_W-1:0]              grant_id,
  output logic                          frame_done
);

  localparam int unsigned CC_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BC_W = $clog2(DATA_WIDTH) + 1;

  logic [1:0]            r_rst_sync;
  logic                  w_rst_n;
  tx_state_e             r_state, w_state_next;
  logic [CC_W-1:0]       r_cc, w_cc_next;
  logic [BC_W-1:0]       r_bc, w_bc_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_next, w_sel_data;
  logic                  r_par, r_tx, w_tx_next;
  logic [GNT_W-1:0]      r_rr_ptr, r_grant_id, w_ptr_next;
  logic [NUM_REQ-1:0]    w_arb_req, w_arb_gnt, w_sel_onehot;
  logic [GNT_W-1:0]      w_arb_idx, w_sel_idx;
  logic                  w_arb_any, w_sel_any, w_upd_ptr, w_accept, w_cc_last;

  // Reset asserts immediately and releases on the second clock edge.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) r_rst_sync <= '0;
    else       r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

`ifdef TX_SCHED_PRIO0_EN
  // Requester 0 bypasses the arbiter; the others rotate without it.
  assign w_arb_req    = {req_valid[NUM_REQ-1:1], 1'b0};
  assign w_sel_any    = req_valid[0] | w_arb_any;
  assign w_sel_onehot = req_valid[0] ? NUM_REQ'(1) : w_arb_gnt;
  assign w_sel_idx    = req_valid[0] ? '0 : w_arb_idx;
  assign w_upd_ptr    = !req_valid[0];
`else
  assign w_arb_req    = req_valid;
  assign w_sel_any    = w_arb_any;
  assign w_sel_onehot = w_arb_gnt;
  assign w_sel_idx    = w_arb_idx;
  assign w_upd_ptr    = 1'b1;
`endif

  tx_frame_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GNT_W   (GNT_W)
  ) u_rr_arbiter (
    .i_req     (w_arb_req),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_arb_gnt),
    .o_gnt_idx (w_arb_idx),
    .o_any     (w_arb_any)
  );

  assign w_sel_data = req_data[w_sel_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_ptr_next = (w_sel_idx == GNT_W'(NUM_REQ-1)) ? '0 : w_sel_idx + 1'b1;
  assign w_accept   = (r_state == ST_IDLE) && w_sel_any && w_rst_n;
  assign w_cc_last  = (r_cc == CC_W'(CLKS_PER_BIT-1));

  // Next-state, counter and shift-register logic; tx is precomputed from
  // the next state so the registered line lines up with the state.
  always_comb begin
    w_state_next = r_state;
    w_cc_next    = r_cc;
    w_bc_next    = r_bc;
    w_shift_next = r_shift;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_START;
          w_shift_next = w_sel_data;
          w_cc_next    = '0;
          w_bc_next    = '0;
        end
      end
      ST_START, ST_PARITY, ST_STOP: begin
        if (w_cc_last) begin
          w_cc_next    = '0;
          w_bc_next    = '0;
          w_state_next = (r_state == ST_START)  ? ST_DATA :
                         (r_state == ST_PARITY) ? ST_STOP : ST_IDLE;
        end else begin
          w_cc_next = r_cc + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_cc_last) begin
          w_cc_next = '0;
          if (r_bc == BC_W'(DATA_WIDTH-1)) begin
            w_bc_next    = '0;
            w_state_next = ST_PARITY;
          end else begin
            w_bc_next    = r_bc + 1'b1;
            w_shift_next = r_shift >> 1;
          end
        end else begin
          w_cc_next = r_cc + 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    case (w_state_next)
      ST_START:  w_tx_next = START_BIT;
      ST_DATA:   w_tx_next = w_shift_next[0];
      ST_PARITY: w_tx_next = r_par;
      ST_STOP:   w_tx_next = STOP_BIT;
      default:   w_tx_next = IDLE_LEVEL;
    endcase
  end

  // Framer state and captured-byte registers.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= ST_IDLE;
      r_cc       <= '0;
      r_bc       <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tx       <= IDLE_LEVEL;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
    end else begin
      r_state <= w_state_next;
      r_cc    <= w_cc_next;
      r_bc    <= w_bc_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
      if (w_accept) begin
        r_par      <= ~^w_sel_data;
        r_grant_id <= w_sel_idx;
        if (w_upd_ptr) r_rr_ptr <= w_ptr_next;
      end
    end
  end

  assign req_ready  = w_accept ? w_sel_onehot : '0;
  assign tx         = r_tx;
  assign busy       = (r_state != ST_IDLE);
  assign grant_id   = r_grant_id;
  assign frame_done = (r_state == ST_STOP) && w_cc_last;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed self-checking bench for tx_frame_scheduler (CPB=1 and CPB=4 instances).
module tb_tx_frame_scheduler;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic [3:0]  req_valid = '0, req_valid4 = '0;
  logic [31:0] req_data = '0, req_data4 = '0;
  logic [3:0]  req_ready, req_ready4;
  logic        tx, busy, frame_done, tx4, busy4, frame_done4;
  logic [1:0]  grant_id, grant_id4;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  tx_frame_scheduler #(.NUM_REQ(4), .DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut (
    .clk(clk), .arst(arst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id),
    .frame_done(frame_done));

  tx_frame_scheduler #(.NUM_REQ(4), .DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .arst(arst), .req_valid(req_valid4), .req_data(req_data4),
    .req_ready(req_ready4), .tx(tx4), .busy(busy4), .grant_id(grant_id4),
    .frame_done(frame_done4));

  task automatic do_reset();
    arst = 1'b0;
    req_valid = '0;
    req_valid4 = '0;
    repeat (2) @(posedge clk);
    #1 arst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Records 11 line cycles starting with the cycle after the acceptance edge.
  task automatic capture(input logic [3:0] v_after, input logic [31:0] d_after,
                         output logic [10:0] bits, output logic [10:0] done,
                         output logic [10:0] bsy, output logic [1:0] gid, output int rc);
    rc = 0;
    gid = '0;
    for (int k = 0; k < 11; k++) begin
      @(posedge clk); #1;
      bits[k] = tx;
      done[k] = frame_done;
      bsy[k]  = busy;
      if (req_ready != 4'b0000) rc++;
      if (k == 0) begin
        gid = grant_id;
        req_valid = v_after;
        req_data  = d_after;
      end
    end
  endtask

  // Waits (bounded) until the CPB=1 instance offers a ready pulse.
  task automatic wait_accept(output bit found, output logic [3:0] rdy);
    found = 1'b0;
    rdy = '0;
    #1;
    for (int c = 0; c < 40 && !found; c++) begin
      if (req_ready != 4'b0000) begin
        found = 1'b1;
        rdy = req_ready;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    arst = 1'b0;
    req_valid = 4'b1111;
    req_valid4 = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({tx, busy, req_ready, grant_id, frame_done} !== {1'b1, 1'b0, 4'b0000, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got tx=%b busy=%b rdy=%b gid=%0d fd=%b exp 1 0 0000 0 0",
               tx, busy, req_ready, grant_id, frame_done);
    end
    checks++;
    if ({tx4, busy4, req_ready4, frame_done4} !== {1'b1, 1'b0, 4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs4 got tx=%b busy=%b rdy=%b fd=%b", tx4, busy4, req_ready4, frame_done4);
    end
    do_reset();
  endtask

  task automatic test_single_frame();
    logic [10:0] bits, done, bsy;
    logic [1:0] gid;
    int rc;
    req_data = 32'h0000_00A5;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_ready got=%b exp=0001", req_ready);
    end
    capture(4'b0000, 32'h0000_0000, bits, done, bsy, gid, rc);
    checks++;
    if (bits !== 11'b11101001010) begin
      failures++;
      $display("FAIL single_bits got=%b exp=11101001010", bits);
    end
    checks++;
    if (done !== 11'b10000000000) begin
      failures++;
      $display("FAIL single_done got=%b exp=10000000000", done);
    end
    checks++;
    if (bsy !== 11'h7FF || rc != 0 || gid !== 2'd0) begin
      failures++;
      $display("FAIL single_busy_ready got busy=%b readies=%0d gid=%0d exp 11111111111 0 0", bsy, rc, gid);
    end
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL single_idle got tx=%b busy=%b fd=%b exp 1 0 0", tx, busy, frame_done);
    end
  endtask

  task automatic test_round_robin();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    logic [10:0] bits, done, bsy;
    logic [1:0] gid;
    logic [3:0] exp_rdy;
    int rc;
    do_reset();
    req_data = 32'h1312_1110;
    req_valid = 4'b1111;
    #1;
    for (int f = 0; f < 5; f++) begin
      exp_rdy = 4'(1 << exp_g[f]);
      checks++;
      if (req_ready !== exp_rdy || busy !== 1'b0 || tx !== 1'b1) begin
        failures++;
        $display("FAIL rr_ready_%0d got rdy=%b busy=%b tx=%b exp rdy=%b 0 1", f, req_ready, busy, tx, exp_rdy);
      end
      capture(4'b1111, 32'h1312_1110, bits, done, bsy, gid, rc);
      checks++;
      if (gid !== 2'(exp_g[f]) || bits[8:1] !== 8'(8'h10 + exp_g[f]) || done !== 11'b10000000000) begin
        failures++;
        $display("FAIL rr_frame_%0d got gid=%0d byte=%h done=%b exp gid=%0d byte=%h", f, gid, bits[8:1],
                 done, exp_g[f], 8'(8'h10 + exp_g[f]));
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  task automatic test_parity();
    logic [7:0] bytes[3] = '{8'hFF, 8'h00, 8'h01};
    logic       pars[3]  = '{1'b1, 1'b1, 1'b0};
    logic [10:0] bits, done, bsy;
    logic [1:0] gid;
    logic [3:0] rdy;
    logic err;
    bit found;
    int rc;
    for (int i = 0; i < 3; i++) begin
      req_data = {16'h0, bytes[i], 8'h0};
      req_valid = 4'b0010;
      wait_accept(found, rdy);
      checks++;
      if (!found || rdy !== 4'b0010) begin
        failures++;
        $display("FAIL parity_accept_%0d got found=%0d rdy=%b exp 1 0010", i, found, rdy);
      end
      capture(4'b0000, req_data, bits, done, bsy, gid, rc);
      err = !(bits[0] == 1'b0 && bits[10] == 1'b1 && (^bits[9:1]) == 1'b1);
      checks++;
      if (err !== 1'b0 || bits[8:1] !== bytes[i] || bits[9] !== pars[i]) begin
        failures++;
        $display("FAIL parity_frame_%0d got err=%b byte=%h par=%b exp err=0 byte=%h par=%b", i, err,
                 bits[8:1], bits[9], bytes[i], pars[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_clks_per_bit();
    logic [10:0] exp11 = 11'b11001111000;
    int bad_tx = 0;
    int bad_done = 0;
    req_data4 = 32'h0000_003C;
    req_valid4 = 4'b0001;
    #1;
    checks++;
    if (req_ready4 !== 4'b0001) begin
      failures++;
      $display("FAIL cpb4_ready got=%b exp=0001", req_ready4);
    end
    for (int k = 0; k < 44; k++) begin
      @(posedge clk); #1;
      if (k == 0) req_valid4 = '0;
      if (tx4 !== exp11[k/4]) bad_tx++;
      if (frame_done4 !== (k == 43)) bad_done++;
    end
    checks++;
    if (bad_tx != 0) begin
      failures++;
      $display("FAIL cpb4_bits got=%0d wrong samples exp=0", bad_tx);
    end
    checks++;
    if (bad_done != 0) begin
      failures++;
      $display("FAIL cpb4_done got=%0d wrong samples exp=0", bad_done);
    end
    @(posedge clk); #1;
    checks++;
    if (busy4 !== 1'b0 || tx4 !== 1'b1) begin
      failures++;
      $display("FAIL cpb4_idle got busy=%b tx=%b exp 0 1", busy4, tx4);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] bits, done, bsy;
    logic [1:0] gid;
    logic [3:0] rdy;
    bit found;
    int rc;
    do_reset();
    req_data = 32'h005A_0000;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL abort_ready got=%b exp=0010", req_ready);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k == 0) req_valid = '0;
    end
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre got tx=%b busy=%b exp 0 1", tx, busy);
    end
    req_valid = 4'b0100;
    arst = 1'b0;
    #1;
    checks++;
    if ({tx, busy, req_ready, frame_done, grant_id} !== {1'b1, 1'b0, 4'b0000, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL abort_now got tx=%b busy=%b rdy=%b fd=%b gid=%0d exp 1 0 0000 0 0", tx, busy,
               req_ready, frame_done, grant_id);
    end
    repeat (2) @(posedge clk);
    #1 arst = 1'b1;
    wait_accept(found, rdy);
    checks++;
    if (!found || rdy !== 4'b0100) begin
      failures++;
      $display("FAIL abort_regrant got found=%0d rdy=%b exp 1 0100", found, rdy);
    end
    capture(4'b0000, req_data, bits, done, bsy, gid, rc);
    checks++;
    if (gid !== 2'd2 || bits !== 11'b11010110100 || done !== 11'b10000000000) begin
      failures++;
      $display("FAIL abort_frame got gid=%0d bits=%b done=%b exp 2 11010110100 10000000000", gid, bits, done);
    end
    @(posedge clk); #1;
  endtask

`ifdef TX_SCHED_PRIO0_EN
  task automatic test_prio0();
    int exp_g[7] = '{0, 0, 0, 1, 2, 3, 1};
    logic [10:0] bits, done, bsy;
    logic [1:0] gid;
    logic [3:0] rdy, v;
    bit found;
    int rc;
    do_reset();
    req_data = 32'h1312_1110;
    for (int f = 0; f < 7; f++) begin
      v = (f < 3) ? 4'b1111 : 4'b1110;
      req_valid = v;
      wait_accept(found, rdy);
      checks++;
      if (!found || rdy !== 4'(1 << exp_g[f])) begin
        failures++;
        $display("FAIL prio_ready_%0d got found=%0d rdy=%b exp=%b", f, found, rdy, 4'(1 << exp_g[f]));
      end
      capture(v, req_data, bits, done, bsy, gid, rc);
      checks++;
      if (gid !== 2'(exp_g[f]) || bits[8:1] !== 8'(8'h10 + exp_g[f])) begin
        failures++;
        $display("FAIL prio_frame_%0d got gid=%0d byte=%h exp gid=%0d", f, gid, bits[8:1], exp_g[f]);
      end
    end
    req_valid = '0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_parity();
    test_clks_per_bit();
    test_reset_mid_frame();
`ifdef TX_SCHED_PRIO0_EN
    test_prio0();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
